// File: rtl/uart_frame_loader.sv
// uart_frame_loader: loads a sync-framed RGB444 image from UART bytes into a frame buffer.
// Define CHECKSUM_EN to append an 8-bit pixel checksum byte and NAK on mismatch.
module uart_frame_loader #(
   parameter int         H_PIX       = 160,
   parameter int         V_PIX       = 120,
   parameter int         ADDR_W      = 15,
   parameter logic [7:0] SYNC0       = 8'hAA,
   parameter logic [7:0] SYNC1       = 8'h55,
   parameter int         TIMEOUT_CYC = 104_167
) (
   input  logic              i_clk_sys,
   input  logic              i_rst_n,
   input  logic              i_rx_done,
   input  logic [7:0]        i_rx_data,
   output logic              o_wr_en,
   output logic [ADDR_W-1:0] o_wr_addr,
   output logic [11:0]       o_wr_data,
   output logic              o_tx_valid,
   output logic [7:0]        o_tx_data,
   input  logic              i_tx_ready,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic              o_err_timeout
);

   localparam int N  = H_PIX * V_PIX;
   localparam int TW = $clog2(TIMEOUT_CYC);
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

`ifdef CHECKSUM_EN
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SYNC   = 3'd1,
      PIX_HI = 3'd2,
      PIX_LO = 3'd3,
      CHK    = 3'd4,
      REPLY  = 3'd5
   } state_t;
`else
   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      SYNC   = 3'd1,
      PIX_HI = 3'd2,
      PIX_LO = 3'd3,
      REPLY  = 3'd5
   } state_t;
`endif

   state_t            state;
   state_t            state_d;
   logic [ADDR_W-1:0] cnt;
   logic [TW-1:0]     tcnt;
   logic [3:0]        red;
   logic [7:0]        reply;
   logic              run;
   logic              timeout;
   logic              last;

   assign run     = (state != IDLE) && (state != REPLY);
   assign timeout = run && !i_rx_done && (tcnt == TW'(TIMEOUT_CYC - 1));
   assign last    = (cnt == ADDR_W'(N - 1));

   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) state <= IDLE;
      else          state <= state_d;
   end

   always_comb begin
      state_d = state;
      unique case (state)
         IDLE:
            if (i_rx_done && i_rx_data == SYNC0) state_d = SYNC;
         SYNC:
            if (i_rx_done) begin
               if (i_rx_data == SYNC1)      state_d = PIX_HI;
               else if (i_rx_data == SYNC0) state_d = SYNC;
               else                         state_d = IDLE;
            end
         PIX_HI:
            if (i_rx_done) state_d = PIX_HI == state ? PIX_LO : state;
         PIX_LO:
            if (i_rx_done) begin
`ifdef CHECKSUM_EN
               state_d = last ? CHK : PIX_HI;
`else
               state_d = last ? REPLY : PIX_HI;
`endif
            end
`ifdef CHECKSUM_EN
         CHK:
            if (i_rx_done) state_d = REPLY;
`endif
         REPLY:
            if (i_tx_ready) state_d = IDLE;
         default:
            state_d = IDLE;
      endcase
      if (timeout) state_d = IDLE;
   end

   always_comb begin
      o_busy     = (state != IDLE);
      o_tx_valid = (state == REPLY);
      o_tx_data  = o_tx_valid ? reply : 8'h00;
   end

   // An rx strobe restarts the byte-gap timer, so a byte on the last cycle wins.
   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n)                        tcnt <= '0;
      else if (!run || i_rx_done || timeout) tcnt <= '0;
      else                                 tcnt <= tcnt + 1'b1;
   end

   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         o_wr_en       <= 1'b0;
         o_wr_addr     <= '0;
         o_wr_data     <= '0;
         o_frame_done  <= 1'b0;
         o_err_timeout <= 1'b0;
         cnt           <= '0;
         red           <= '0;
      end else begin
         o_wr_en      <= 1'b0;
         o_frame_done <= 1'b0;
         if (timeout) begin
            o_err_timeout <= 1'b1;
            cnt           <= '0;
         end else if (i_rx_done) begin
            if (state == IDLE && i_rx_data == SYNC0) o_err_timeout <= 1'b0;
            if (state == SYNC)   cnt <= '0;
            if (state == PIX_HI) red <= i_rx_data[3:0];
            if (state == PIX_LO) begin
               o_wr_en      <= 1'b1;
               o_wr_addr    <= cnt;
               o_wr_data    <= {red, i_rx_data};
               o_frame_done <= last;
               if (!last) cnt <= cnt + 1'b1;
            end
         end
      end
   end

`ifdef CHECKSUM_EN
   logic [7:0] sum;
   logic       nak;

   always_ff @(posedge i_clk_sys or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sum <= '0;
         nak <= 1'b0;
      end else if (i_rx_done) begin
         if (state == SYNC) sum <= '0;
         if (state == PIX_HI || state == PIX_LO) sum <= sum + i_rx_data;
         if (state == CHK) nak <= (i_rx_data != sum);
      end
   end

   assign reply = nak ? NAK : ACK;
`else
   assign reply = ACK;
`endif

endmodule
